// File: rtl/handshake_fork_buffered_pkg.sv
// Shared defaults for the buffered handshake fork.
// Holds only the default parameter values used by the top level and
// its sub-blocks. No types are needed: every signal here is a plain vector.
package handshake_fork_buffered_pkg;

  localparam int unsigned DEFAULT_SIZE      = 2;
  localparam int unsigned DEFAULT_DATA_TYPE = 32;

endpackage : handshake_fork_buffered_pkg

// File: rtl/handshake_fork_buffered_reg.sv
// eager_fork_register_block: per-output delivery tracking for an eager fork.
// The sent flag records that this output has already taken the current
// token, so its valid drops while the other outputs catch up.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   valid       token valid at the fork input
//   ready       this output's downstream ready
//   block_stop  whole token completes this cycle (all outputs done)
//   out_valid   this output's valid
//   done        this output has taken, or is taking, the token
module eager_fork_register_block (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic ready,
  input  logic block_stop,
  output logic out_valid,
  output logic done
);

  logic sent;

  assign out_valid = valid & ~sent;
  assign done      = sent | ready;

  // The flag is cleared in the cycle the last outstanding output handshakes,
  // so the next token starts with every output undelivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent <= 1'b0;
    end else begin
      sent <= valid & done & ~block_stop;
    end
  end

endmodule : eager_fork_register_block

// File: rtl/handshake_fork_buffered_tehb.sv
// tehb_type: one-entry transparent elastic half buffer.
// When empty, the token passes straight through with no added latency.
// When the consumer stalls a valid token, the token is captured so that
// ins_ready no longer depends combinationally on outs_ready.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   ins         input token data
//   ins_valid   input token valid
//   ins_ready   input accepted (high whenever the buffer is empty)
//   outs        buffered or pass-through data
//   outs_valid  output valid
//   outs_ready  downstream ready
module tehb_type
  import handshake_fork_buffered_pkg::*;
#(
  parameter int unsigned DATA_TYPE = DEFAULT_DATA_TYPE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  logic                 full;
  logic [DATA_TYPE-1:0] buf_data;

  assign ins_ready  = ~full;
  assign outs_valid = full | ins_valid;
  assign outs       = full ? buf_data : ins;

  // Capture only a token that arrives while empty and is not taken at once.
  // While full, no new input is accepted, so buf_data cannot be overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      buf_data <= '0;
    end else if (!full && ins_valid && !outs_ready) begin
      full     <= 1'b1;
      buf_data <= ins;
    end else if (full && outs_ready) begin
      full     <= 1'b0;
    end
  end

endmodule : tehb_type

// File: rtl/handshake_fork_buffered.sv
// handshake_fork_buffered: replicates one input token to SIZE consumers.
// A transparent one-entry buffer on the input cuts the ready path from the
// consumers back to the producer. Each output fires independently; the
// token is retired only once every output has accepted it.
//
// Handshake: a transfer on any channel happens on a rising clk edge where
// both valid and ready are high. Valid, once raised, stays high with stable
// data until that transfer; ready may change freely.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   ins         input token data (DATA_TYPE bits)
//   ins_valid   input token valid
//   ins_ready   input accepted
//   outs        SIZE copies of the token; slice i = [i*DATA_TYPE +: DATA_TYPE]
//   outs_valid  per-output valid
//   outs_ready  per-output ready
module handshake_fork_buffered
  import handshake_fork_buffered_pkg::*;
#(
  parameter int unsigned SIZE      = DEFAULT_SIZE,
  parameter int unsigned DATA_TYPE = DEFAULT_DATA_TYPE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);

  logic                 int_valid;
  logic [DATA_TYPE-1:0] int_data;
  logic                 int_ready;
  logic [SIZE-1:0]      done;

  tehb_type #(
    .DATA_TYPE (DATA_TYPE)
  ) u_tehb (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (int_data),
    .outs_valid (int_valid),
    .outs_ready (int_ready)
  );

  // The token is retired when every output has either taken it earlier or
  // takes it in this cycle.
  assign int_ready = &done;

  assign outs = {SIZE{int_data}};

  for (genvar i = 0; i < SIZE; i++) begin : g_out
    eager_fork_register_block u_reg (
      .clk        (clk),
      .rst        (rst),
      .valid      (int_valid),
      .ready      (outs_ready[i]),
      .block_stop (int_ready),
      .out_valid  (outs_valid[i]),
      .done       (done[i])
    );
  end

endmodule : handshake_fork_buffered
